// File: rtl/vga_face_sequencer.sv
// Frame-synchronous face/filter selector for the vga_face streamer.
// Requests are staged and only applied on the last accepted pixel of a frame.
module vga_face_sequencer #(
    parameter int AUTO_FRAMES = 120,
    parameter int NUM_FACES   = 3,
    parameter int NUM_FILTERS = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        next_face_req,
    input  logic        next_filter_req,
    input  logic        set_valid,
    input  logic [1:0]  set_face,
    input  logic [2:0]  set_filter,
    input  logic        auto_en,
    input  logic        st_valid,
    input  logic        st_ready,
    input  logic        st_eop,
    output logic [1:0]  face_select,
    output logic [2:0]  filter_select,
    output logic        pending,
    output logic        change_ack,
    output logic        set_err,
    output logic [15:0] frame_count
);

    typedef enum logic {IDLE, STAGED} state_e;

    localparam logic [1:0]  F_LAST  = 2'(NUM_FACES - 1);
    localparam logic [2:0]  L_LAST  = 3'(NUM_FILTERS - 1);
    localparam logic [15:0] DW_LAST = 16'(AUTO_FRAMES - 1);

    state_e      state_q;
    logic [1:0]  face_q, stg_face_q, stg_face_d, fin_face;
    logic [2:0]  filt_q, stg_filt_q, stg_filt_d;
    logic [15:0] dwell_q, dwell_d, fcnt_q;
    logic        ack_q, err_q;
    logic        boundary, legal, set_ok, set_bad, manual, auto_adv;

    function automatic logic [1:0] inc_face(input logic [1:0] x);
        return (x == F_LAST) ? 2'd0 : x + 2'd1;
    endfunction

    function automatic logic [2:0] inc_filt(input logic [2:0] x);
        return (x == L_LAST) ? 3'd0 : x + 3'd1;
    endfunction

    always_comb begin
        boundary = st_valid & st_ready & st_eop;
        legal    = (32'(set_face) < NUM_FACES) &&
                   (32'(set_filter) < NUM_FILTERS);
        set_ok   = set_valid & legal;
        set_bad  = set_valid & ~legal;
        manual   = set_ok | next_face_req | next_filter_req;

        // The staged pair mirrors the applied pair while idle.
        stg_face_d = stg_face_q;
        stg_filt_d = stg_filt_q;
        if (set_ok) begin
            stg_face_d = set_face;
            stg_filt_d = set_filter;
        end else begin
            if (next_face_req)   stg_face_d = inc_face(stg_face_q);
            if (next_filter_req) stg_filt_d = inc_filt(stg_filt_q);
        end

        auto_adv = auto_en & boundary & ~manual & (dwell_q == DW_LAST);
        fin_face = auto_adv ? inc_face(stg_face_d) : stg_face_d;

        dwell_d = dwell_q;
        if (!auto_en || manual || auto_adv) dwell_d = 16'd0;
        else if (boundary)                  dwell_d = dwell_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            face_q     <= 2'd0;
            filt_q     <= 3'd0;
            stg_face_q <= 2'd0;
            stg_filt_q <= 3'd0;
            dwell_q    <= 16'd0;
            fcnt_q     <= 16'd0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q   <= set_bad;
            ack_q   <= 1'b0;
            dwell_q <= dwell_d;
            if (boundary) begin
                face_q     <= fin_face;
                filt_q     <= stg_filt_d;
                stg_face_q <= fin_face;
                stg_filt_q <= stg_filt_d;
                fcnt_q     <= fcnt_q + 16'd1;
                ack_q      <= (fin_face != face_q) | (stg_filt_d != filt_q);
                state_q    <= IDLE;
            end else begin
                stg_face_q <= stg_face_d;
                stg_filt_q <= stg_filt_d;
                if (manual) state_q <= STAGED;
            end
        end
    end

    assign face_select   = face_q;
    assign filter_select = filt_q;
    assign pending       = (state_q == STAGED);
    assign change_ack    = ack_q;
    assign set_err       = err_q;
    assign frame_count   = fcnt_q;

endmodule

// File: tb/tb_vga_face_sequencer.sv
// Scoreboard bench for vga_face_sequencer: directed stimulus queues expected
// outputs per cycle, an independent monitor pops and compares them.
module tb_vga_face_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        next_face_req = 1'b0, next_filter_req = 1'b0, set_valid = 1'b0;
    logic [1:0]  set_face = '0;
    logic [2:0]  set_filter = '0;
    logic        auto_en = 1'b0;
    logic        st_valid = 1'b0, st_ready = 1'b0, st_eop = 1'b0;
    logic [1:0]  face_select;
    logic [2:0]  filter_select;
    logic        pending, change_ack, set_err;
    logic [15:0] frame_count;

    vga_face_sequencer #(.AUTO_FRAMES(4), .NUM_FACES(3), .NUM_FILTERS(5)) dut (
        .clk(clk), .reset(reset),
        .next_face_req(next_face_req), .next_filter_req(next_filter_req),
        .set_valid(set_valid), .set_face(set_face), .set_filter(set_filter),
        .auto_en(auto_en),
        .st_valid(st_valid), .st_ready(st_ready), .st_eop(st_eop),
        .face_select(face_select), .filter_select(filter_select),
        .pending(pending), .change_ack(change_ack), .set_err(set_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          at;
        logic [1:0]  f;
        logic [2:0]  l;
        logic        p, a, e;
        logic [15:0] fc;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (x.at < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed", x.nm, x.at);
            end else if (face_select !== x.f || filter_select !== x.l ||
                         pending !== x.p || change_ack !== x.a ||
                         set_err !== x.e || frame_count !== x.fc) begin
                errors++;
                $display("FAIL %s: got f=%0d l=%0d p=%0d a=%0d e=%0d fc=%0d, want f=%0d l=%0d p=%0d a=%0d e=%0d fc=%0d",
                         x.nm, face_select, filter_select, pending, change_ack,
                         set_err, frame_count, x.f, x.l, x.p, x.a, x.e, x.fc);
            end
        end
    end

    task automatic expect_at(input int d, input int f, input int l, input bit p,
                             input bit a, input bit e, input int fc,
                             input string nm);
        exp_t x;
        x.at = cyc + d;
        x.f  = 2'(f);
        x.l  = 3'(l);
        x.p  = p;
        x.a  = a;
        x.e  = e;
        x.fc = 16'(fc);
        x.nm = nm;
        q.push_back(x);
    endtask

    task automatic step(input bit nf, input bit nl, input bit sv,
                        input logic [1:0] sf, input logic [2:0] sl,
                        input bit bnd);
        next_face_req   = nf;
        next_filter_req = nl;
        set_valid       = sv;
        set_face        = sf;
        set_filter      = sl;
        st_valid        = bnd;
        st_ready        = bnd;
        st_eop          = bnd;
        @(posedge clk);
        #1;
        next_face_req   = 1'b0;
        next_filter_req = 1'b0;
        set_valid       = 1'b0;
        set_face        = '0;
        set_filter      = '0;
        st_valid        = 1'b0;
        st_ready        = 1'b0;
        st_eop          = 1'b0;
    endtask

    task automatic idle();
        step(0, 0, 0, 2'd0, 3'd0, 0);
    endtask

    int fseq [13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        expect_at(0, 0, 0, 0, 0, 0, 0, "reset");
        repeat (10) idle();

        // Single face request, boundary 40 cycles later.
        expect_at(1, 0, 0, 1, 0, 0, 0, "t1_pend");
        expect_at(40, 0, 0, 1, 0, 0, 0, "t1_hold");
        expect_at(41, 1, 0, 0, 1, 0, 1, "t1_apply");
        expect_at(42, 1, 0, 0, 0, 0, 1, "t1_ackoff");
        step(1, 0, 0, 2'd0, 3'd0, 0);
        repeat (39) idle();
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();
        idle();

        // Three face requests wrap back; a stalled eop is not a boundary.
        expect_at(1, 1, 0, 1, 0, 0, 1, "t2_pend");
        expect_at(6, 1, 0, 1, 0, 0, 1, "t2_stall");
        expect_at(7, 1, 0, 0, 0, 0, 2, "t2_wrap");
        step(1, 0, 0, 2'd0, 3'd0, 0);
        idle();
        step(1, 0, 0, 2'd0, 3'd0, 0);
        idle();
        step(1, 0, 0, 2'd0, 3'd0, 0);
        st_valid = 1'b1;
        st_eop   = 1'b1;
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_eop   = 1'b0;
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();

        // Set plus next_filter on a boundary cycle: set wins, applied directly.
        expect_at(0, 1, 0, 0, 0, 0, 2, "t3_before");
        expect_at(1, 2, 4, 0, 1, 0, 3, "t3_apply");
        expect_at(2, 2, 4, 0, 0, 0, 3, "t3_ackoff");
        step(0, 1, 1, 2'd2, 3'd4, 1);
        idle();
        idle();

        // Illegal face code: error, next_filter still honoured (4 wraps to 0).
        expect_at(1, 2, 4, 1, 0, 1, 3, "t4_err");
        expect_at(2, 2, 4, 1, 0, 0, 3, "t4_errclr");
        expect_at(4, 2, 0, 0, 1, 0, 4, "t4_apply");
        step(0, 1, 1, 2'd3, 3'd2, 0);
        idle();
        idle();
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();

        // Illegal filter code alone: nothing staged, no ack.
        expect_at(1, 2, 0, 0, 0, 1, 4, "t4_badfilt");
        expect_at(3, 2, 0, 0, 0, 0, 5, "t4_noack");
        step(0, 0, 1, 2'd0, 3'd5, 0);
        idle();
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();

        // Reset while staged discards the change.
        expect_at(1, 2, 0, 1, 0, 0, 5, "t5_pend");
        expect_at(3, 0, 0, 0, 0, 0, 0, "t5_reset");
        expect_at(4, 0, 0, 0, 0, 0, 1, "t5_after");
        step(0, 1, 0, 2'd0, 3'd0, 0);
        idle();
        reset = 1'b1;
        idle();
        reset = 1'b0;
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();

        // Auto-cycle with AUTO_FRAMES=4 over 12 boundaries.
        auto_en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            expect_at(0, fseq[k-1], 0, 0, 0, 0, k, "t6_seq");
            if (k % 4 == 0)
                expect_at(1, fseq[k], 0, 0, 1, 0, k + 1, "t6_adv");
            step(0, 0, 0, 2'd0, 3'd0, 1);
            idle();
        end

        // A manual request restarts the dwell count.
        repeat (3) begin
            step(0, 0, 0, 2'd0, 3'd0, 1);
            idle();
        end
        expect_at(1, 0, 0, 1, 0, 0, 16, "t7_pend");
        step(0, 1, 0, 2'd0, 3'd0, 0);
        idle();
        expect_at(1, 0, 1, 0, 1, 0, 17, "t7_apply");
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();
        expect_at(1, 0, 1, 0, 0, 0, 19, "t7_noauto");
        step(0, 0, 0, 2'd0, 3'd0, 1);
        idle();
        auto_en = 1'b0;

        for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
